knight_sprite_animator: RTL and testbench
=========================================

// Module: knight_sprite_animator
// PURPOSE
//  Sits directly upstream of the knight sprite ROM/palette stage. Per pixel,
//  turns DrawX/DrawY plus the knight's on-screen position into the sprite ROM
//  address, an in-box flag and an animation frame select (idle/walk1/walk2).
//  Position, facing and animation frame are updated only once per video frame
//  (vsync falling edge), so the sprite never tears mid-frame.
// PARAMETERS
//  SPRITE_W    30  sprite width in pixels
//  SPRITE_H    64  sprite height in pixels
//  ADDR_W      11  ROM address width; must hold SPRITE_W*SPRITE_H-1
//  FRAME_HOLD  8   video frames each walk frame is held (>=1)
// PORTS
//  vga_clk      in   1       pixel clock; all state on posedge
//  Reset        in   1       asynchronous, active-high reset
//  vsync        in   1       VGA vsync (active low); falling edge = frame tick
//  DrawX        in   10      current pixel column
//  DrawY        in   10      current pixel row
//  pos_x        in   10      requested sprite top-left column
//  pos_y        in   10      requested sprite top-left row
//  walking      in   1       1 = animate walk cycle, 0 = idle pose
//  face_left    in   1       1 = mirror sprite horizontally
//  rom_address  out  ADDR_W  address into the selected sprite ROM
//  frame_sel    out  2       0 idle, 1 walk1, 2 walk2 (3 never driven)
//  sprite_on    out  1       1 = current pixel lies inside the sprite box
// BEHAVIOUR
//  Reset (async): rom_address=0, frame_sel=0, sprite_on=0, state=IDLE,
//   hold_cnt=0, latched x/y/face=0, vsync_q=0 (no tick until a real 1->0).
//  Frame tick: vsync_q <= vsync each cycle; tick = vsync_q & ~vsync (1 cycle).
//  On tick only: lat_x<=pos_x, lat_y<=pos_y, lat_face<=face_left, FSM steps.
//   Inputs changing between ticks have no effect on outputs.
//  FSM (advances only on tick):
//   IDLE : walking -> WALK1, hold_cnt=0; else stay.
//   WALK1: !walking -> IDLE, hold_cnt=0; hold_cnt==FRAME_HOLD-1 -> WALK2,
//          hold_cnt=0; else hold_cnt++.
//   WALK2: same as WALK1 but wraps back to WALK1.
//   frame_sel = 0/1/2 for IDLE/WALK1/WALK2; changes in the cycle after tick.
//  Pixel path (1 cycle latency, registered on posedge vga_clk):
//   dx = DrawX - lat_x, dy = DrawY - lat_y, 10-bit unsigned wrap-around.
//   inbox = (dx < SPRITE_W) && (dy < SPRITE_H); pixels left/above the box
//    wrap to large values and are outside.
//   col = lat_face ? SPRITE_W-1-dx : dx.
//   rom_address <= inbox ? dy*SPRITE_W + col : 0; sprite_on <= inbox.
//   Product computed at >=ADDR_W bits; no truncation for legal params.
//  Box clipped by screen edge: only on-screen pixels ever assert sprite_on.
//  Downstream ROM reads on negedge of vga_clk, so address valid half a cycle
//   before ROM sample; consumer sees data one cycle after DrawX/DrawY.
//  Reset mid-frame: outputs return to reset values immediately; first
//   position latch occurs at the next genuine vsync falling edge.
//  walking toggled 1->0->1 between ticks: only value at tick matters.
// TESTING
//  1 Reset held, vsync toggling -> rom_address=0, frame_sel=0, sprite_on=0.
//  2 Tick with pos=(100,50), face_left=0; DrawX=100,DrawY=50 -> next cycle
//    addr=0, on=1; (129,113) -> addr=1919, on=1; (130,50) -> on=0, addr=0.
//  3 face_left=1, same pos: (100,50) -> addr=29; (129,51) -> addr=30.
//  4 walking=1, FRAME_HOLD=8: frame_sel 0->1 at tick 1, ->2 at tick 9, ->1 at
//    tick 17; drop walking before tick 20 -> frame_sel=0 after tick 20.
//  5 Change pos_x 100->200 mid-frame: sprite_on still at DrawX=100 until the
//    next vsync fall, then at 200 only.
//  6 pos=(620,460): pixel (639,479) -> on=1, addr=19*30... =(19*30+19)=589;
//    DrawX=5 (wrap) -> on=0. Reset asserted mid-walk -> frame_sel=0 at once.

Source files
------------

// File: rtl/knight_sprite_animator_if.sv
// Pixel/position bus between the video timing + game logic side (master)
// and the knight sprite animator (slave).
interface knight_sprite_animator_if #(
    parameter int ADDR_W = 11
);
    logic              vsync;
    logic [9:0]        DrawX;
    logic [9:0]        DrawY;
    logic [9:0]        pos_x;
    logic [9:0]        pos_y;
    logic              walking;
    logic              face_left;
    logic [ADDR_W-1:0] rom_address;
    logic [1:0]        frame_sel;
    logic              sprite_on;

    modport master (
        output vsync, DrawX, DrawY, pos_x, pos_y, walking, face_left,
        input  rom_address, frame_sel, sprite_on
    );

    modport slave (
        input  vsync, DrawX, DrawY, pos_x, pos_y, walking, face_left,
        output rom_address, frame_sel, sprite_on
    );
endinterface

// File: rtl/knight_sprite_animator.sv
// Knight sprite animator: per-pixel ROM address / in-box flag generation and
// a once-per-video-frame walk animation sequencer.
//
//  state | meaning
//  ------+------------------------------------------------------------
//  IDLE  | standing pose, frame_sel = 0
//  WALK1 | first walk frame, frame_sel = 1, held FRAME_HOLD ticks
//  WALK2 | second walk frame, frame_sel = 2, held FRAME_HOLD ticks
//
// Position, facing and state only move on a vsync falling edge so the
// sprite cannot tear within a displayed frame.
module knight_sprite_animator #(
    parameter int SPRITE_W   = 30,
    parameter int SPRITE_H   = 64,
    parameter int ADDR_W     = 11,
    parameter int FRAME_HOLD = 8
) (
    input  logic                      vga_clk,
    input  logic                      Reset,
    knight_sprite_animator_if.slave   bus
);
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int HOLD_W   = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
    localparam int PROD_W   = (ADDR_W > 20) ? ADDR_W : 20;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(FRAME_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WALK1 = 2'd1,
        WALK2 = 2'd2
    } state_t;

    state_t            state;
    logic [HOLD_W-1:0] hold_cnt;
    logic              vsync_q;
    logic              tick;
    logic [9:0]        lat_x;
    logic [9:0]        lat_y;
    logic              lat_face;

    logic [9:0]        dx;
    logic [9:0]        dy;
    logic [9:0]        col;
    logic              on_screen;
    logic              inbox;
    logic [PROD_W-1:0] addr_full;

    // vsync_q resets to 0 so a low vsync at reset release is not a tick
    assign tick = vsync_q & ~bus.vsync;

    // Delay vsync by one cycle for falling-edge detection
    always_ff @(posedge vga_clk or posedge Reset) begin
        if (Reset) vsync_q <= 1'b0;
        else       vsync_q <= bus.vsync;
    end

    // Capture position and facing once per video frame
    always_ff @(posedge vga_clk or posedge Reset) begin
        if (Reset) begin
            lat_x    <= '0;
            lat_y    <= '0;
            lat_face <= 1'b0;
        end else if (tick) begin
            lat_x    <= bus.pos_x;
            lat_y    <= bus.pos_y;
            lat_face <= bus.face_left;
        end
    end

    // Animation sequencer with registered frame select, stepped on tick
    always_ff @(posedge vga_clk or posedge Reset) begin
        if (Reset) begin
            state         <= IDLE;
            hold_cnt      <= '0;
            bus.frame_sel <= 2'd0;
        end else if (tick) begin
            case (state)
                IDLE: begin
                    if (bus.walking) begin
                        state         <= WALK1;
                        hold_cnt      <= '0;
                        bus.frame_sel <= 2'd1;
                    end
                end
                WALK1, WALK2: begin
                    if (!bus.walking) begin
                        state         <= IDLE;
                        hold_cnt      <= '0;
                        bus.frame_sel <= 2'd0;
                    end else if (hold_cnt == HOLD_LAST) begin
                        hold_cnt <= '0;
                        if (state == WALK1) begin
                            state         <= WALK2;
                            bus.frame_sel <= 2'd2;
                        end else begin
                            state         <= WALK1;
                            bus.frame_sel <= 2'd1;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state         <= IDLE;
                    hold_cnt      <= '0;
                    bus.frame_sel <= 2'd0;
                end
            endcase
        end
    end

    // Box test and address arithmetic; pixels left/above the box wrap high
    always_comb begin
        dx        = bus.DrawX - lat_x;
        dy        = bus.DrawY - lat_y;
        col       = lat_face ? (10'(SPRITE_W - 1) - dx) : dx;
        on_screen = (bus.DrawX < 10'(SCREEN_W)) && (bus.DrawY < 10'(SCREEN_H));
        inbox     = on_screen && (dx < 10'(SPRITE_W)) && (dy < 10'(SPRITE_H));
        addr_full = PROD_W'(dy) * PROD_W'(SPRITE_W) + PROD_W'(col);
    end

    // Register pixel outputs; address is forced to 0 outside the box
    always_ff @(posedge vga_clk or posedge Reset) begin
        if (Reset) begin
            bus.rom_address <= '0;
            bus.sprite_on   <= 1'b0;
        end else begin
            bus.rom_address <= inbox ? addr_full[ADDR_W-1:0] : '0;
            bus.sprite_on   <= inbox;
        end
    end
endmodule

// File: tb/tb_knight_sprite_animator.sv
// Self-checking bench for knight_sprite_animator: fixed vector table,
// hand-written walk/reset sequences and a randomized run against a model.
module tb_knight_sprite_animator;
    localparam int SW   = 30;
    localparam int SH   = 64;
    localparam int HOLD = 8;

    logic vga_clk = 1'b0;
    logic Reset   = 1'b1;
    always #5 vga_clk = ~vga_clk;

    knight_sprite_animator_if #(.ADDR_W(11)) bus ();

    knight_sprite_animator #(
        .SPRITE_W(SW), .SPRITE_H(SH), .ADDR_W(11), .FRAME_HOLD(HOLD)
    ) dut (
        .vga_clk(vga_clk),
        .Reset  (Reset),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: latched view plus number of consecutive walking ticks
    int m_lat_x = 0, m_lat_y = 0, m_face = 0, m_walk_n = 0;

    typedef struct {
        int px; int py; int face;
        int x;  int y;
        int on; int addr;
    } vec_t;
    vec_t vecs[12];

    function automatic int exp_on(int x, int y);
        int dx, dy;
        dx = (x - m_lat_x + 1024) % 1024;
        dy = (y - m_lat_y + 1024) % 1024;
        return (x < 640 && y < 480 && dx < SW && dy < SH) ? 1 : 0;
    endfunction

    function automatic int exp_addr(int x, int y);
        int dx, dy;
        dx = (x - m_lat_x + 1024) % 1024;
        dy = (y - m_lat_y + 1024) % 1024;
        if (exp_on(x, y) == 0) return 0;
        return dy * SW + (m_face != 0 ? SW - 1 - dx : dx);
    endfunction

    function automatic int exp_frame();
        if (m_walk_n == 0) return 0;
        return (((m_walk_n - 1) / HOLD) % 2) + 1;
    endfunction

    task automatic step();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", nm, act, exp);
        end
    endtask

    task automatic pixel(string nm, int x, int y);
        bus.DrawX = 10'(x);
        bus.DrawY = 10'(y);
        step();
        check({nm, "_on"},    32'(bus.sprite_on),   32'(exp_on(x, y)));
        check({nm, "_addr"},  32'(bus.rom_address), 32'(exp_addr(x, y)));
        check({nm, "_frame"}, 32'(bus.frame_sel),   32'(exp_frame()));
    endtask

    task automatic tick(int px, int py, int face, int walk);
        bus.pos_x     = 10'(px);
        bus.pos_y     = 10'(py);
        bus.face_left = 1'(face);
        bus.walking   = 1'(walk);
        bus.vsync     = 1'b1;
        step();
        bus.vsync     = 1'b0;
        step();
        m_lat_x  = px;
        m_lat_y  = py;
        m_face   = face;
        m_walk_n = (walk != 0) ? m_walk_n + 1 : 0;
        bus.vsync = 1'b1;
        check("tick_frame", 32'(bus.frame_sel), 32'(exp_frame()));
    endtask

    initial begin
        vecs[0]  = '{100, 50, 0, 100,  50, 1, 0};
        vecs[1]  = '{100, 50, 0, 129, 113, 1, 1919};
        vecs[2]  = '{100, 50, 0, 130,  50, 0, 0};
        vecs[3]  = '{100, 50, 0,  99,  50, 0, 0};
        vecs[4]  = '{100, 50, 0, 100, 114, 0, 0};
        vecs[5]  = '{100, 50, 1, 100,  50, 1, 29};
        vecs[6]  = '{100, 50, 1, 129,  51, 1, 30};
        vecs[7]  = '{100, 50, 1, 129, 113, 1, 1890};
        vecs[8]  = '{620, 460, 0, 639, 479, 1, 589};
        vecs[9]  = '{620, 460, 0,   5, 479, 0, 0};
        vecs[10] = '{620, 460, 0, 620, 460, 1, 0};
        vecs[11] = '{620, 460, 0, 645, 470, 0, 0};

        bus.vsync = 1'b0; bus.DrawX = '0; bus.DrawY = '0;
        bus.pos_x = 10'd100; bus.pos_y = 10'd50;
        bus.walking = 1'b1; bus.face_left = 1'b0;

        // reset held while vsync toggles: outputs stay at reset values
        for (int i = 0; i < 6; i++) begin
            bus.vsync = ~bus.vsync;
            bus.DrawX = 10'(100 + i);
            bus.DrawY = 10'd50;
            step();
            check("rst_on",    32'(bus.sprite_on),   32'd0);
            check("rst_addr",  32'(bus.rom_address), 32'd0);
            check("rst_frame", 32'(bus.frame_sel),   32'd0);
        end
        bus.walking = 1'b0;
        bus.vsync   = 1'b1;
        Reset       = 1'b0;
        step();

        // fixed vectors; a tick is issued whenever position/facing changes
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].px != m_lat_x || vecs[i].py != m_lat_y || vecs[i].face != m_face)
                tick(vecs[i].px, vecs[i].py, vecs[i].face, 0);
            bus.DrawX = 10'(vecs[i].x);
            bus.DrawY = 10'(vecs[i].y);
            step();
            check($sformatf("vec%0d_on", i),   32'(bus.sprite_on),   32'(vecs[i].on));
            check($sformatf("vec%0d_addr", i), 32'(bus.rom_address), 32'(vecs[i].addr));
        end

        // mid-frame position change has no effect until the next tick
        tick(100, 50, 0, 0);
        pixel("pre_100", 100, 50);
        bus.pos_x = 10'd200;
        step();
        pixel("mid_100", 100, 50);
        pixel("mid_200", 200, 50);
        tick(200, 50, 0, 0);
        pixel("post_100", 100, 50);
        pixel("post_200", 200, 50);

        // walk cycle: 1 at tick 1, 2 at tick 9, 1 at tick 17, idle at tick 20
        for (int t = 1; t <= 20; t++) begin
            if (t % 3 == 0) begin
                bus.walking = 1'b0; step();
                bus.walking = 1'b1; step();
            end
            tick(200, 50, 0, (t == 20) ? 0 : 1);
            if (t == 1)  check("walk_t1",  32'(bus.frame_sel), 32'd1);
            if (t == 9)  check("walk_t9",  32'(bus.frame_sel), 32'd2);
            if (t == 17) check("walk_t17", 32'(bus.frame_sel), 32'd1);
            if (t == 20) check("walk_t20", 32'(bus.frame_sel), 32'd0);
        end

        // reset in the middle of a walk returns outputs to zero at once
        for (int t = 0; t < 10; t++) tick(200, 50, 0, 1);
        pixel("pre_rst", 205, 60);
        @(negedge vga_clk);
        Reset = 1'b1;
        #1;
        check("async_rst_frame", 32'(bus.frame_sel),   32'd0);
        check("async_rst_on",    32'(bus.sprite_on),   32'd0);
        check("async_rst_addr",  32'(bus.rom_address), 32'd0);
        m_lat_x = 0; m_lat_y = 0; m_face = 0; m_walk_n = 0;
        bus.vsync = 1'b0;
        step();
        Reset = 1'b0;
        step();
        pixel("norel_tick_0", 100, 50);
        pixel("norel_tick_1", 10, 10);
        tick(300, 200, 1, 1);
        pixel("after_rst", 300, 200);

        // randomized frames, mid-frame input noise and pixels
        for (int i = 0; i < 600; i++) begin
            int op, x, y;
            op = int'($urandom_range(15));
            if (op == 0) begin
                tick(int'($urandom_range(639)), int'($urandom_range(479)),
                     int'($urandom_range(1)), (int'($urandom_range(3)) != 0) ? 1 : 0);
            end else if (op == 1) begin
                bus.pos_x     = 10'($urandom_range(1023));
                bus.pos_y     = 10'($urandom_range(1023));
                bus.face_left = 1'($urandom_range(1));
                bus.walking   = 1'($urandom_range(1));
                step();
            end else begin
                if (op < 10) begin
                    x = (m_lat_x + int'($urandom_range(40)) - 5 + 1024) % 1024;
                    y = (m_lat_y + int'($urandom_range(74)) - 5 + 1024) % 1024;
                end else begin
                    x = int'($urandom_range(799));
                    y = int'($urandom_range(524));
                end
                pixel("rand", x, y);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
